// File: rtl/cluster_clock_gate_ctrl_pkg.sv
// Shared types and constants for the cluster clock-gate controller.
// Latency: none (type and constant definitions only).
// Backpressure: none.
//
// Contents: controller state encoding, statistics counter width and a
// small elaboration-time helper used to size the idle/wake counter.
package cluster_clk_gate_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        IDLE_CNT = 2'd1,
        OFF      = 2'd2,
        WAKE     = 2'd3
    } clk_gate_state_e;

    localparam int unsigned STATS_W = 32;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/cluster_clock_gate_ctrl_if.sv
// Control/handshake bundle between the power manager and the clock-gate controller.
// Latency: none (wires only).
// Backpressure: four-phase off_req_i/off_ack_o; all other signals are plain levels.
//
// master: power manager / activity sources (drive the *_i signals).
// slave : cluster_clock_gate_ctrl (drives the *_o signals).
// CLUSTER_CLK_GATE_STATS_EN adds stats_clr_i / gated_cycles_o.
interface cluster_clock_gate_ctrl_if;
    import cluster_clk_gate_pkg::*;

    logic       auto_gate_en_i;
    logic       busy_i;
    logic       wake_i;
    logic       off_req_i;
    logic       off_ack_o;
    logic       clk_en_o;
    logic       clk_ready_o;
    logic [1:0] state_o;
`ifdef CLUSTER_CLK_GATE_STATS_EN
    logic               stats_clr_i;
    logic [STATS_W-1:0] gated_cycles_o;
`endif

    modport master (
        output auto_gate_en_i, busy_i, wake_i, off_req_i,
`ifdef CLUSTER_CLK_GATE_STATS_EN
        output stats_clr_i,
        input  gated_cycles_o,
`endif
        input  off_ack_o, clk_en_o, clk_ready_o, state_o
    );

    modport slave (
        input  auto_gate_en_i, busy_i, wake_i, off_req_i,
`ifdef CLUSTER_CLK_GATE_STATS_EN
        input  stats_clr_i,
        output gated_cycles_o,
`endif
        output off_ack_o, clk_en_o, clk_ready_o, state_o
    );

endinterface

// File: rtl/cluster_clock_gate_cnt.sv
// Saturating up-counter with synchronous clear, increment enable and terminal flag.
// Latency: count updates on the clock edge after clr_i/inc_i; tc_o is combinational from the count.
// Backpressure: none; once the count reaches term_i further increments are dropped.
//
// Ports: clk_i, rst_i (sync, active-high), clr_i (wins over inc_i), inc_i,
//        term_i (terminal value, may change per cycle), cnt_o, tc_o (cnt_o >= term_i).
module cluster_clock_gate_cnt #(
    parameter int unsigned W = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         clr_i,
    input  logic         inc_i,
    input  logic [W-1:0] term_i,
    output logic [W-1:0] cnt_o,
    output logic         tc_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // ">=" rather than "==" so a count that is already past a lowered
    // terminal (term_i switches with the controller state) still saturates.
    assign tc_o  = (cnt_q >= term_i);
    assign cnt_o = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && !tc_o) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/cluster_clock_gate_ctrl.sv
// Enable generator for the cluster ICG: idle auto-gating, four-phase explicit off, wake with settle window.
// Latency: all outputs registered; clk_en_o follows the transition decision by one cycle.
// Backpressure: off_req_i is acknowledged only once clk_en_o is already 0; requests during WAKE wait for RUN.
//
// Ports: clk_i (free-running cluster clock), rst_i (sync, active-high),
//        ctrl (slave side of cluster_clock_gate_ctrl_if: auto_gate_en_i, busy_i,
//        wake_i, off_req_i -> off_ack_o, clk_en_o, clk_ready_o, state_o).
// Optional: CLUSTER_CLK_GATE_STATS_EN adds stats_clr_i / gated_cycles_o (gated-cycle count).
module cluster_clock_gate_ctrl
    import cluster_clk_gate_pkg::*;
#(
    parameter int unsigned IDLE_CYCLES = 16,
    parameter int unsigned WAKE_CYCLES = 2
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    cluster_clock_gate_ctrl_if.slave  ctrl
);

    localparam int unsigned CNT_MAX = max_u(IDLE_CYCLES, WAKE_CYCLES);
    localparam int          CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] IDLE_TC   = CNT_W'(IDLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] WAKE_TC   = CNT_W'(WAKE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX_V = CNT_W'(CNT_MAX);

    clk_gate_state_e state_q, state_d;
    logic            clk_en_q, clk_en_d;
    logic            clk_ready_q, clk_ready_d;
    logic            off_ack_q, off_ack_d;
    // Remembers that OFF is held by (or was entered through) an explicit
    // request, so dropping off_req_i alone is enough to leave OFF.
    logic            off_explicit_q, off_explicit_d;

    logic             cnt_clr;
    logic             cnt_inc;
    logic [CNT_W-1:0] cnt_term;
    logic [CNT_W-1:0] cnt_val;
    logic             cnt_tc;
    logic             idle_done;

    // WAKE saturates at its settle length; everywhere else the counter may
    // run up to the largest terminal so RUN->IDLE_CNT can always load 1.
    assign cnt_term  = (state_q == WAKE) ? WAKE_TC : CNT_MAX_V;
    // With IDLE_CYCLES=1 the entry count (1) is already past IDLE_TC (0).
    assign idle_done = (cnt_val >= IDLE_TC);

    cluster_clock_gate_cnt #(
        .W (CNT_W)
    ) u_cnt (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .clr_i  (cnt_clr),
        .inc_i  (cnt_inc),
        .term_i (cnt_term),
        .cnt_o  (cnt_val),
        .tc_o   (cnt_tc)
    );

    always_comb begin
        state_d = state_q;
        cnt_clr = 1'b0;
        cnt_inc = 1'b0;

        case (state_q)
            RUN: begin
                if (ctrl.off_req_i && !ctrl.busy_i) begin
                    state_d = OFF;
                    cnt_clr = 1'b1;
                end else if (ctrl.auto_gate_en_i && !ctrl.busy_i && !ctrl.wake_i) begin
                    // Entry cycle is the first idle cycle: counter becomes 1.
                    state_d = IDLE_CNT;
                    cnt_inc = 1'b1;
                end else begin
                    cnt_clr = 1'b1;
                end
            end

            IDLE_CNT: begin
                if (ctrl.busy_i || ctrl.wake_i || !ctrl.auto_gate_en_i) begin
                    state_d = RUN;
                    cnt_clr = 1'b1;
                end else if (ctrl.off_req_i || idle_done) begin
                    state_d = OFF;
                    cnt_clr = 1'b1;
                end else begin
                    cnt_inc = 1'b1;
                end
            end

            OFF: begin
                cnt_clr = 1'b1;
                if (!ctrl.off_req_i &&
                    (off_explicit_q || ctrl.wake_i || ctrl.busy_i || !ctrl.auto_gate_en_i)) begin
                    state_d = WAKE;
                end
            end

            WAKE: begin
                // off_req_i is deliberately not looked at here; RUN picks it up.
                if (cnt_tc) begin
                    state_d = RUN;
                    cnt_clr = 1'b1;
                end else begin
                    cnt_inc = 1'b1;
                end
            end

            default: begin
                state_d = RUN;
                cnt_clr = 1'b1;
            end
        endcase
    end

    // Outputs are registered from the next state, so they change together
    // with state_o one cycle after the decision.
    always_comb begin
        clk_en_d       = (state_d != OFF);
        clk_ready_d    = (state_d == RUN) || (state_d == IDLE_CNT);
        // Acknowledge only from a cycle already in OFF: the enable has dropped
        // one cycle earlier, and the ack falls with the exit decision.
        off_ack_d      = (state_q == OFF) && (state_d == OFF) && ctrl.off_req_i;
        off_explicit_d = (state_d == OFF) && (off_explicit_q || ctrl.off_req_i);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q        <= RUN;
            clk_en_q       <= 1'b1;
            clk_ready_q    <= 1'b1;
            off_ack_q      <= 1'b0;
            off_explicit_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            clk_en_q       <= clk_en_d;
            clk_ready_q    <= clk_ready_d;
            off_ack_q      <= off_ack_d;
            off_explicit_q <= off_explicit_d;
        end
    end

    assign ctrl.clk_en_o    = clk_en_q;
    assign ctrl.clk_ready_o = clk_ready_q;
    assign ctrl.off_ack_o   = off_ack_q;
    assign ctrl.state_o     = state_q;

`ifdef CLUSTER_CLK_GATE_STATS_EN
    logic [STATS_W-1:0] stats_val;
    logic               stats_sat;

    // Counts cycles in which the registered enable is low; holds at all-ones.
    cluster_clock_gate_cnt #(
        .W (STATS_W)
    ) u_stats_cnt (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .clr_i  (ctrl.stats_clr_i),
        .inc_i  (!clk_en_q && !stats_sat),
        .term_i ({STATS_W{1'b1}}),
        .cnt_o  (stats_val),
        .tc_o   (stats_sat)
    );

    assign ctrl.gated_cycles_o = stats_val;
`endif

endmodule

// File: tb/tb_cluster_clock_gate_ctrl.sv
// Directed bench for cluster_clock_gate_ctrl: one instance with IDLE=16/WAKE=2
// and one with IDLE=1/WAKE=0 for the minimum-parameter corner.
// Optional stats checks are compiled in with CLUSTER_CLK_GATE_STATS_EN.
module tb_cluster_clock_gate_ctrl;
    import cluster_clk_gate_pkg::*;

    logic clk_i = 1'b0;
    logic rst_i;
    int   checks = 0;
    int   errors = 0;

    always #5 clk_i = ~clk_i;

    cluster_clock_gate_ctrl_if a_if ();
    cluster_clock_gate_ctrl_if b_if ();

    cluster_clock_gate_ctrl #(
        .IDLE_CYCLES (16),
        .WAKE_CYCLES (2)
    ) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .ctrl  (a_if)
    );

    cluster_clock_gate_ctrl #(
        .IDLE_CYCLES (1),
        .WAKE_CYCLES (0)
    ) dut_min (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .ctrl  (b_if)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_a(input string tag, input logic [1:0] st, input logic en,
                         input logic rdy, input logic ack);
        chk({tag, ".state"}, 32'(a_if.state_o), 32'(st));
        chk({tag, ".clk_en"}, 32'(a_if.clk_en_o), 32'(en));
        chk({tag, ".ready"}, 32'(a_if.clk_ready_o), 32'(rdy));
        chk({tag, ".ack"}, 32'(a_if.off_ack_o), 32'(ack));
    endtask

    task automatic chk_b(input string tag, input logic [1:0] st, input logic en,
                         input logic rdy, input logic ack);
        chk({tag, ".state"}, 32'(b_if.state_o), 32'(st));
        chk({tag, ".clk_en"}, 32'(b_if.clk_en_o), 32'(en));
        chk({tag, ".ready"}, 32'(b_if.clk_ready_o), 32'(rdy));
        chk({tag, ".ack"}, 32'(b_if.off_ack_o), 32'(ack));
    endtask

    // Advance n rising edges and land 1 time unit after the last one.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    initial begin
        rst_i = 1'b1;
        a_if.auto_gate_en_i = 1'b0; a_if.busy_i = 1'b0;
        a_if.wake_i = 1'b0;         a_if.off_req_i = 1'b0;
        b_if.auto_gate_en_i = 1'b0; b_if.busy_i = 1'b0;
        b_if.wake_i = 1'b0;         b_if.off_req_i = 1'b0;
`ifdef CLUSTER_CLK_GATE_STATS_EN
        a_if.stats_clr_i = 1'b0;
        b_if.stats_clr_i = 1'b0;
`endif
        tick(2);
        chk_a("reset", RUN, 1'b1, 1'b1, 1'b0);
        chk_b("reset_min", RUN, 1'b1, 1'b1, 1'b0);

        // Auto-gating after exactly 16 idle cycles.
        rst_i = 1'b0;
        a_if.auto_gate_en_i = 1'b1;
        tick(15);
        chk_a("idle15", IDLE_CNT, 1'b1, 1'b1, 1'b0);
        tick(1);
        chk_a("autogate", OFF, 1'b0, 1'b0, 1'b0);
        tick(2);
        chk_a("off_hold", OFF, 1'b0, 1'b0, 1'b0);

        // Wake from auto-gated OFF: WAKE for 3 cycles, then RUN.
        a_if.wake_i = 1'b1;
        tick(1);
        chk_a("wake_enter", WAKE, 1'b1, 1'b0, 1'b0);
        a_if.wake_i = 1'b0;
        tick(2);
        chk_a("wake_settle", WAKE, 1'b1, 1'b0, 1'b0);
        a_if.busy_i = 1'b1;
        tick(1);
        chk_a("wake_done", RUN, 1'b1, 1'b1, 1'b0);
        tick(1);

        // Idle count interrupted at 10 restarts the full 16-cycle window.
        a_if.busy_i = 1'b0;
        tick(10);
        chk_a("idle10", IDLE_CNT, 1'b1, 1'b1, 1'b0);
        a_if.busy_i = 1'b1;
        tick(1);
        chk_a("busy_abort", RUN, 1'b1, 1'b1, 1'b0);
        a_if.busy_i = 1'b0;
        tick(15);
        chk_a("reidle15", IDLE_CNT, 1'b1, 1'b1, 1'b0);
        tick(1);
        chk_a("regate", OFF, 1'b0, 1'b0, 1'b0);

        // Disabling auto-gating leaves OFF.
        a_if.auto_gate_en_i = 1'b0;
        tick(1);
        chk_a("autodis_wake", WAKE, 1'b1, 1'b0, 1'b0);
        tick(3);
        chk_a("autodis_run", RUN, 1'b1, 1'b1, 1'b0);

        // Explicit off: blocked while busy, ack one cycle after enable drops,
        // wake ignored while held, release goes through WAKE.
        a_if.busy_i = 1'b1;
        a_if.off_req_i = 1'b1;
        tick(1);
        chk_a("off_busy", RUN, 1'b1, 1'b1, 1'b0);
        a_if.busy_i = 1'b0;
        tick(1);
        chk_a("off_gate", OFF, 1'b0, 1'b0, 1'b0);
        tick(1);
        chk_a("off_ack", OFF, 1'b0, 1'b0, 1'b1);
        a_if.wake_i = 1'b1;
        tick(1);
        chk_a("off_wake_ign", OFF, 1'b0, 1'b0, 1'b1);
        a_if.wake_i = 1'b0;
        a_if.off_req_i = 1'b0;
        tick(1);
        chk_a("off_release", WAKE, 1'b1, 1'b0, 1'b0);
        tick(2);
        chk_a("off_settle", WAKE, 1'b1, 1'b0, 1'b0);
        tick(1);
        chk_a("off_run", RUN, 1'b1, 1'b1, 1'b0);

        // Request withdrawn before ack; a new request during WAKE waits for RUN.
        a_if.off_req_i = 1'b1;
        tick(1);
        chk_a("wd_gate", OFF, 1'b0, 1'b0, 1'b0);
        a_if.off_req_i = 1'b0;
        tick(1);
        chk_a("wd_wake", WAKE, 1'b1, 1'b0, 1'b0);
        a_if.off_req_i = 1'b1;
        tick(2);
        chk_a("wake_req_held", WAKE, 1'b1, 1'b0, 1'b0);
        tick(1);
        chk_a("wake_req_run", RUN, 1'b1, 1'b1, 1'b0);
        tick(1);
        chk_a("deferred_off", OFF, 1'b0, 1'b0, 1'b0);
        tick(1);
        chk_a("deferred_ack", OFF, 1'b0, 1'b0, 1'b1);

        // Reset while OFF with ack high.
        rst_i = 1'b1;
        tick(1);
        chk_a("rst_in_off", RUN, 1'b1, 1'b1, 1'b0);
        rst_i = 1'b0;
        a_if.off_req_i = 1'b0;
        tick(1);
        chk_a("post_rst", RUN, 1'b1, 1'b1, 1'b0);

        // Minimum parameters: IDLE_CYCLES=1, WAKE_CYCLES=0.
        b_if.auto_gate_en_i = 1'b1;
        tick(1);
        chk_b("min_idle", IDLE_CNT, 1'b1, 1'b1, 1'b0);
        tick(1);
        chk_b("min_gate", OFF, 1'b0, 1'b0, 1'b0);
        b_if.wake_i = 1'b1;
        tick(1);
        chk_b("min_wake", WAKE, 1'b1, 1'b0, 1'b0);
        b_if.wake_i = 1'b0;
        b_if.auto_gate_en_i = 1'b0;
        tick(1);
        chk_b("min_ready", RUN, 1'b1, 1'b1, 1'b0);

`ifdef CLUSTER_CLK_GATE_STATS_EN
        // Gated-cycle statistics: 40 gated cycles, then clear while gated.
        a_if.stats_clr_i = 1'b1;
        a_if.auto_gate_en_i = 1'b1;
        tick(16);
        chk_a("stats_gate", OFF, 1'b0, 1'b0, 1'b0);
        chk("stats_start", a_if.gated_cycles_o, 32'd0);
        a_if.stats_clr_i = 1'b0;
        tick(40);
        chk("stats_40", a_if.gated_cycles_o, 32'd40);
        a_if.stats_clr_i = 1'b1;
        tick(1);
        chk("stats_clr", a_if.gated_cycles_o, 32'd0);
        a_if.stats_clr_i = 1'b0;
        tick(2);
        chk("stats_resume", a_if.gated_cycles_o, 32'd2);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
